// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: the host command record and the read-return owner tag.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 16;

  typedef struct packed {
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
  } vram_cmd_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_HOST} vram_tag_t;

endpackage

// File: rtl/vram_arbiter_cmd_fifo.sv
// In-order host command FIFO; full is registered so a pop never re-opens the input in the same cycle.
module vram_arbiter_cmd_fifo
  import vram_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  vram_cmd_t        din,
  input  logic             pop,
  output vram_cmd_t        dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  vram_cmd_t        storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign dout    = storage[rd_ptr];

  // NOTE: every combinational output gets its default first, so no path can infer a latch.
  always_comb begin
    level_n = level;
    if (do_push && !do_pop)      level_n = level + 1'b1;
    else if (do_pop && !do_push) level_n = level - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  // full resets high, holding the input closed until the first clock out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_n;
      full  <= (level_n == LVL_W'(DEPTH));
    end
  end

  // NOTE: payload storage is not reset; the pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch has hard priority, host commands fill idle cycles in order.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter  int ADDR_W       = VRAM_ADDR_W,
  parameter  int DATA_W       = VRAM_DATA_W,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int STARVE_LIMIT = 1024,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              I_clk_pixel,
  input  logic              I_reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_rvalid,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  cmd_level,
  output logic              starve,
  input  logic              starve_clr
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  vram_cmd_t        cmd_in;
  vram_cmd_t        head;
  logic             full;
  logic             empty;
  logic             pop;
  vram_tag_t        tag;
  vram_tag_t        tag_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_n;

  assign cmd_in    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;

  vram_arbiter_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (I_clk_pixel),
    .rst_n (I_reset_n),
    .push  (cmd_valid && cmd_ready),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (cmd_level)
  );

  // Issue is gated by reset so the memory sees no access while the arbiter is held.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag       = TAG_NONE;
    pop       = 1'b0;
    if (I_reset_n) begin
      if (fetch_req) begin
        mem_ce   = 1'b1;
        mem_addr = fetch_addr;
        tag      = TAG_FETCH;
      end else if (!empty) begin
        pop       = 1'b1;
        mem_ce    = 1'b1;
        mem_we    = head.we;
        mem_addr  = head.addr;
        mem_wdata = head.wdata;
        tag       = head.we ? TAG_NONE : TAG_HOST;
      end
    end
  end

  always_comb begin
    starve_cnt_n = starve_cnt;
    if (pop)
      starve_cnt_n = '0;
    else if (!empty && fetch_req && starve_cnt != CNT_W'(STARVE_LIMIT))
      starve_cnt_n = starve_cnt + 1'b1;
  end

  // tag_q names the owner of the read whose data arrives on mem_rdata this cycle.
  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      tag_q       <= TAG_NONE;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      cmd_rvalid  <= 1'b0;
      cmd_rdata   <= '0;
      starve_cnt  <= '0;
      starve      <= 1'b0;
    end else begin
      tag_q       <= tag;
      fetch_valid <= (tag_q == TAG_FETCH);
      cmd_rvalid  <= (tag_q == TAG_HOST);
      if (tag_q == TAG_FETCH) fetch_data <= mem_rdata;
      if (tag_q == TAG_HOST)  cmd_rdata  <= mem_rdata;
      starve_cnt <= starve_cnt_n;
      starve     <= (starve_cnt_n == CNT_W'(STARVE_LIMIT)) || (starve && !starve_clr);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM preloaded with addr+0x100.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_rvalid;
  logic [DW-1:0] cmd_rdata;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    cmd_level;
  logic          starve;
  logic          starve_clr;

  logic [DW-1:0] ram [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .I_clk_pixel (clk),
    .I_reset_n   (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_rvalid  (cmd_rvalid),
    .cmd_rdata   (cmd_rdata),
    .mem_ce      (mem_ce),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .cmd_level   (cmd_level),
    .starve      (starve),
    .starve_clr  (starve_clr)
  );

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    starve_clr = 1'b0;
  endtask

  task automatic offer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic          q_we   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [AW-1:0] q_addr [5] = '{12'h040, 12'h041, 12'h042, 12'h041, 12'h040};
  logic [DW-1:0] q_data [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000};

  logic          il_fr  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [AW-1:0] il_fa  [7] = '{12'h050, 12'h000, 12'h051, 12'h000, 12'h052, 12'h000, 12'h000};
  logic          il_ce  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [AW-1:0] il_ma  [7] = '{12'h050, 12'h020, 12'h051, 12'h040, 12'h052, 12'h000, 12'h000};
  logic          il_fv  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          il_rv  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [DW-1:0] il_fd  [7] = '{16'h0, 16'h0, 16'h0150, 16'h0, 16'h0151, 16'h0, 16'h0152};
  logic [DW-1:0] il_rd  [7] = '{16'h0, 16'h0, 16'h0, 16'hBEEF, 16'h0, 16'h1111, 16'h0};

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = DW'(a + 'h100);
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    next_cycle();
    @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_ce", mem_ce, 0);
    check("rst_level", cmd_level, 0);
    check("rst_fvalid", fetch_valid, 0);
    check("rst_rvalid", cmd_rvalid, 0);
    check("rst_starve", starve, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_clock", cmd_ready, 0);
    next_cycle();
    @(negedge clk);
    check("ready_after_first_clock", cmd_ready, 1);
    next_cycle();

    // Fetch only: 0x010..0x013 back-to-back, data two cycles later
    for (int i = 0; i < 7; i++) begin
      fetch_req  = (i < 4);
      fetch_addr = AW'(12'h010 + i);
      @(negedge clk);
      if (i < 4) begin
        check("fetch_ce", mem_ce, 1);
        check("fetch_addr", mem_addr, 32'h010 + i);
      end
      if (i >= 2 && i < 6) begin
        check("fetch_valid", fetch_valid, 1);
        check("fetch_data", fetch_data, 32'h110 + i - 2);
      end else begin
        check("fetch_valid_idle", fetch_valid, 0);
      end
      next_cycle();
    end
    idle_inputs();

    // Idle host: write 0xBEEF to 0x020, then read it back
    offer(1'b1, 12'h020, 16'hBEEF);
    @(negedge clk);
    check("wr_accept_ready", cmd_ready, 1);
    check("wr_no_issue_yet", mem_ce, 0);
    next_cycle();
    offer(1'b0, 12'h020, 16'h0000);
    @(negedge clk);
    check("wr_issue_ce", mem_ce, 1);
    check("wr_issue_we", mem_we, 1);
    check("wr_issue_addr", mem_addr, 32'h020);
    check("wr_issue_data", mem_wdata, 32'hBEEF);
    check("wr_level", cmd_level, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_issue_we", mem_we, 0);
    check("rd_issue_addr", mem_addr, 32'h020);
    check("push_pop_level", cmd_level, 1);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid_early", cmd_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid", cmd_rvalid, 1);
    check("rd_rdata", cmd_rdata, 32'hBEEF);
    check("rd_no_fvalid", fetch_valid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid_pulse", cmd_rvalid, 0);
    check("rd_rdata_hold", cmd_rdata, 32'hBEEF);
    next_cycle();

    // Full FIFO with fetch held: four pushes, fifth blocked until the first pop
    fetch_req  = 1'b1;
    fetch_addr = 12'h030;
    for (int i = 0; i < 4; i++) begin
      offer(q_we[i], q_addr[i], q_data[i]);
      @(negedge clk);
      check("fill_ready", cmd_ready, 1);
      check("fill_level", cmd_level, i);
      check("fill_fetch_addr", mem_addr, 32'h030);
      next_cycle();
    end
    offer(q_we[4], q_addr[4], q_data[4]);
    @(negedge clk);
    check("full_ready", cmd_ready, 0);
    check("full_level", cmd_level, 4);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    check("full_pop_ready", cmd_ready, 0);
    check("pop0_we", mem_we, 1);
    check("pop0_addr", mem_addr, 32'h040);
    check("pop0_data", mem_wdata, 32'h1111);
    next_cycle();
    @(negedge clk);
    check("ready_reopen", cmd_ready, 1);
    check("pop1_addr", mem_addr, 32'h041);
    check("pop1_level", cmd_level, 3);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("pushpop_level", cmd_level, 3);
    check("pop2_addr", mem_addr, 32'h042);
    next_cycle();
    @(negedge clk);
    check("pop3_we", mem_we, 0);
    check("pop3_addr", mem_addr, 32'h041);
    next_cycle();
    @(negedge clk);
    check("pop4_addr", mem_addr, 32'h040);
    check("pop4_level", cmd_level, 1);
    next_cycle();
    @(negedge clk);
    check("drain_ce", mem_ce, 0);
    check("q_rd1_rvalid", cmd_rvalid, 1);
    check("q_rd1_rdata", cmd_rdata, 32'h2222);
    next_cycle();
    @(negedge clk);
    check("q_rd2_rvalid", cmd_rvalid, 1);
    check("q_rd2_rdata", cmd_rdata, 32'h1111);
    check("drain_level", cmd_level, 0);
    next_cycle();

    // Interleave fetch and host slots
    for (int i = 0; i < 7; i++) begin
      fetch_req  = il_fr[i];
      fetch_addr = il_fa[i];
      if (i == 0)      offer(1'b0, 12'h020, 16'h0000);
      else if (i == 1) offer(1'b0, 12'h040, 16'h0000);
      else             cmd_valid = 1'b0;
      @(negedge clk);
      check("il_ce", mem_ce, il_ce[i]);
      check("il_addr", mem_addr, il_ma[i]);
      check("il_fvalid", fetch_valid, il_fv[i]);
      check("il_rvalid", cmd_rvalid, il_rv[i]);
      check("il_no_overlap", fetch_valid && cmd_rvalid, 0);
      if (il_fv[i]) check("il_fdata", fetch_data, il_fd[i]);
      if (il_rv[i]) check("il_rdata", cmd_rdata, il_rd[i]);
      next_cycle();
    end
    idle_inputs();

    // Starvation with limit 8; clear coinciding with set keeps the flag
    for (int i = 0; i < 14; i++) begin
      fetch_req  = (i <= 10);
      fetch_addr = 12'h055;
      if (i == 0) offer(1'b1, 12'h060, 16'hAAAA);
      else        cmd_valid = 1'b0;
      starve_clr = (i == 10 || i == 12);
      @(negedge clk);
      check("starve", starve, (i >= 9 && i <= 12));
      next_cycle();
    end
    idle_inputs();

    // Reset the cycle after a host read issues
    offer(1'b0, 12'h020, 16'h0000);
    @(negedge clk);
    check("rm_idle_ce", mem_ce, 0);
    next_cycle();
    offer(1'b1, 12'h070, 16'h5555);
    @(negedge clk);
    check("rm_issue_ce", mem_ce, 1);
    check("rm_issue_addr", mem_addr, 32'h020);
    next_cycle();
    idle_inputs();
    fetch_req  = 1'b1;
    fetch_addr = 12'h080;
    rst_n      = 1'b0;
    @(negedge clk);
    check("rm_ce", mem_ce, 0);
    check("rm_we", mem_we, 0);
    check("rm_addr", mem_addr, 0);
    check("rm_wdata", mem_wdata, 0);
    next_cycle();
    rst_n     = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    check("rm_rvalid", cmd_rvalid, 0);
    check("rm_level", cmd_level, 0);
    check("rm_ce_after", mem_ce, 0);
    check("rm_ready_held", cmd_ready, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rm_rvalid_late", cmd_rvalid, 0);
      check("rm_fvalid_late", fetch_valid, 0);
      check("rm_ready", cmd_ready, 1);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one synchronous single-port VRAM between two requesters in the pixel clock domain:
  - the background pixel fetch inside the video generator, which has hard priority and a fixed latency;
  - the UART/COBS command decoder, which issues host reads and writes through a valid/ready port.
- Host commands are buffered in a small in-order FIFO and issued only on cycles when the fetch port does not use the memory.
- Host starvation is detected with a counter and reported through a sticky flag.

Parameters:
- ADDR_W, 12, VRAM word address width.
- DATA_W, 16, VRAM word width.
- FIFO_DEPTH, 4, host command FIFO entries; must be a power of two and at least 2.
- STARVE_LIMIT, 1024, consecutive blocked cycles before the starvation flag is set.

Ports:
- I_clk_pixel  in  1  pixel clock; the only clock.
- I_reset_n  in  1  synchronous, active-low reset.
- fetch_req  in  1  pixel fetch read request for this cycle.
- fetch_addr  in  ADDR_W  pixel fetch address.
- fetch_valid  out  1  fetch_data is valid this cycle.
- fetch_data  out  DATA_W  pixel fetch read data.
- cmd_valid  in  1  host command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  host address.
- cmd_wdata  in  DATA_W  host write data.
- cmd_rvalid  out  1  cmd_rdata is valid this cycle.
- cmd_rdata  out  DATA_W  host read data.
- mem_ce  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid 1 cycle after a read with mem_ce=1.
- cmd_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- starve  out  1  sticky starvation flag.
- starve_clr  in  1  clears starve.

Behaviour:
- Reset values: all outputs are 0, except cmd_ready=1 after the first clock with I_reset_n=1. Reset also flushes the FIFO, in-flight tags and the starve counter.
- Accept: a command is pushed when cmd_valid && cmd_ready. cmd_ready = (cmd_level != FIFO_DEPTH) and is registered from the count.
  - When full, a simultaneous pop does not re-open cmd_ready in the same cycle.
- Issue (combinational mem_* outputs, decided each cycle):
  - if fetch_req: mem_ce=1, mem_we=0, mem_addr=fetch_addr; tag = FETCH.
  - else if the FIFO is non-empty: pop the head; mem_ce=1, mem_we=head.we, mem_addr/mem_wdata from head; tag = HOST for a read, none for a write.
  - else: mem_ce=0.
- Return pipeline: a 1-deep tag register captures the read owner at issue.
  - The next cycle, mem_rdata is registered into the owner's data output.
  - fetch_valid / cmd_rvalid pulse on the cycle after that.
  - Fixed read latency: fetch_req at cycle N gives fetch_valid at N+2, every time.
- Outputs hold data between valid pulses. The two valids are never high in the same cycle.
- Ordering:
  - Host commands execute in acceptance order, so a host read after a host write to the same address returns the new data.
  - A fetch to an address with a write still queued returns the old data. This is allowed.
- Latency: a command accepted at cycle N with no fetch traffic issues at N+1. A host read then gives cmd_rvalid at N+3.
- Push and pop in the same cycle leave cmd_level unchanged.
- Starve counter:
  - increments on each cycle where the FIFO is non-empty and fetch_req=1;
  - resets to 0 on every pop;
  - saturates at STARVE_LIMIT.
- starve is set when the counter reaches STARVE_LIMIT and is cleared by starve_clr. If set and clear coincide, set wins.
- Reset mid-operation: in-flight tags are dropped, so no valid pulse appears after reset releases for a read issued before reset.

Decomposition:
- configPackage additions:
  - VRAM_ADDR_W, VRAM_DATA_W constants;
  - typedef struct packed {logic we; logic [VRAM_ADDR_W-1:0] addr; logic [VRAM_DATA_W-1:0] wdata;} vram_cmd_t;
  - typedef enum {TAG_NONE, TAG_FETCH, TAG_HOST} vram_tag_t.
- One sub-module, cmd_fifo:
  - synchronous FIFO of vram_cmd_t with push, pop, full, empty and level;
  - same clock and reset.

Test Plan:
- Fetch only: fetch_req=1 for addr 0x010..0x013 on consecutive cycles, memory model returns addr+0x100 → fetch_valid on 4 consecutive cycles starting 2 cycles later, data 0x110..0x113.
- Idle host: write 0xBEEF to 0x020, then read 0x020 with fetch_req=0 → write issues 1 cycle after accept; cmd_rdata=0xBEEF; cmd_rvalid 3 cycles after the read is accepted.
- Full FIFO: fetch_req held high while the host pushes 5 commands → cmd_ready=0 after 4; cmd_level=4. Drop fetch_req → 4 issues in order; cmd_ready returns the cycle after the first pop.
- Interleave: alternate fetch_req 1/0 with the FIFO non-empty → host slots use only the idle cycles; fetch latency stays exactly 2; valids never overlap.
- Starvation: STARVE_LIMIT=8, fetch_req held high with 1 command queued → starve=1 after 8 cycles. starve_clr together with a new set condition keeps starve=1.
- Reset mid-operation: assert I_reset_n=0 the cycle after a host read issues → no cmd_rvalid; cmd_level=0; all mem_* outputs are 0.
